// File: rtl/cbg_lsu_responder_pkg.sv
// Shared slice layouts, default sizes and bank state type for the LSU responder.
package cbg_lsu_responder_pkg;

    localparam int unsigned DEF_N_LSU  = 4;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 10;

    // Request slice: {wdata, addr}; response slice: {rd_valid, wr_ack, rd_data}
    localparam int unsigned ADDR_LSB    = 0;
    localparam int unsigned RD_DATA_LSB = 0;

    function automatic int unsigned wdata_lsb(input int unsigned addr_w);
        return ADDR_LSB + addr_w;
    endfunction

    function automatic int unsigned wr_ack_bit(input int unsigned data_w);
        return RD_DATA_LSB + data_w;
    endfunction

    function automatic int unsigned rd_valid_bit(input int unsigned data_w);
        return RD_DATA_LSB + data_w + 1;
    endfunction

    typedef enum logic {
        BANK_IDLE,
        BANK_BUSY
    } bank_state_e;

endpackage

// File: rtl/cbg_lsu_responder_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant and the pointer for the next cycle.
module cbg_rr_arbiter #(
    parameter int unsigned N_LSU = 4,
    parameter int unsigned PTR_W = (N_LSU > 1) ? $clog2(N_LSU) : 1
) (
    input  logic [N_LSU-1:0] req,
    input  logic [N_LSU-1:0] mask,
    input  logic             hold,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_LSU-1:0] grant,
    output logic [PTR_W-1:0] ptr_next
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        if (!hold) begin
            for (int unsigned k = 0; k < N_LSU; k++) begin
                idx = (32'(ptr) + k) % N_LSU;
                if (!found && req[idx] && !mask[idx]) begin
                    grant[idx] = 1'b1;
                    ptr_next   = PTR_W'((idx + 1) % N_LSU);
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cbg_lsu_responder.sv
// LSU-facing responder: arbitrates LSU requests onto a single-port bank, 1-cycle response.
// Optional stall counter port enabled by defining CBG_PERF_CNT_EN.
module cbg_lsu_responder
    import cbg_lsu_responder_pkg::*;
#(
    parameter int unsigned N_LSU  = DEF_N_LSU,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_LSU-1:0]                  r_request,
    input  logic [N_LSU-1:0]                  w_request,
    input  logic [N_LSU*(DATA_W+ADDR_W)-1:0]  lsu_addr_bus,
    output logic [N_LSU*(DATA_W+2)-1:0]       cbg_to_lsu_bus,
    input  logic                              host_we,
    input  logic [ADDR_W-1:0]                 host_addr,
    input  logic [DATA_W-1:0]                 host_wdata
`ifdef CBG_PERF_CNT_EN
    ,
    output logic [31:0]                       stall_cnt
`endif
);

    localparam int unsigned REQ_W        = DATA_W + ADDR_W;
    localparam int unsigned RSP_W        = DATA_W + 2;
    localparam int unsigned PTR_W        = (N_LSU > 1) ? $clog2(N_LSU) : 1;
    localparam int unsigned WDATA_LSB    = wdata_lsb(ADDR_W);
    localparam int unsigned WR_ACK_BIT   = wr_ack_bit(DATA_W);
    localparam int unsigned RD_VALID_BIT = rd_valid_bit(DATA_W);

    logic [DATA_W-1:0] bank [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data [N_LSU];
    logic [N_LSU-1:0]  req, mask, grant, rsp_rd, rsp_wr;
    logic [PTR_W-1:0]  ptr, ptr_next;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_write;
    bank_state_e       state;

    assign req = r_request | w_request;

    cbg_rr_arbiter #(
        .N_LSU (N_LSU),
        .PTR_W (PTR_W)
    ) u_arb (
        .req      (req),
        .mask     (mask),
        .hold     (host_we),
        .ptr      (ptr),
        .grant    (grant),
        .ptr_next (ptr_next)
    );

    // A write wins over a read from the same LSU; the read is picked up on a later grant.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int unsigned i = 0; i < N_LSU; i++) begin
            if (grant[i]) begin
                sel_addr  = lsu_addr_bus[i*REQ_W + ADDR_LSB +: ADDR_W];
                sel_wdata = lsu_addr_bus[i*REQ_W + WDATA_LSB +: DATA_W];
                sel_write = w_request[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (host_we)
            bank[host_addr] <= host_wdata;
        else if (|grant && sel_write)
            bank[sel_addr] <= sel_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= BANK_IDLE;
            ptr    <= '0;
            mask   <= '0;
            rsp_rd <= '0;
            rsp_wr <= '0;
            for (int unsigned i = 0; i < N_LSU; i++)
                rd_data[i] <= '0;
        end else begin
            ptr    <= ptr_next;
            mask   <= grant;
            rsp_rd <= sel_write ? '0 : grant;
            rsp_wr <= sel_write ? grant : '0;
            for (int unsigned i = 0; i < N_LSU; i++)
                if (grant[i] && !sel_write)
                    rd_data[i] <= bank[sel_addr];
            case (state)
                BANK_IDLE: state <= (|grant || host_we) ? BANK_BUSY : BANK_IDLE;
                BANK_BUSY: state <= (|grant) ? BANK_BUSY : BANK_IDLE;
                default:   state <= BANK_IDLE;
            endcase
        end
    end

`ifdef CBG_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (|(req & ~mask & ~grant) && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

    always_comb begin
        cbg_to_lsu_bus = '0;
        for (int unsigned i = 0; i < N_LSU; i++) begin
            cbg_to_lsu_bus[i*RSP_W + RD_VALID_BIT] = (state == BANK_BUSY) && rsp_rd[i];
            cbg_to_lsu_bus[i*RSP_W + WR_ACK_BIT]   = (state == BANK_BUSY) && rsp_wr[i];
            cbg_to_lsu_bus[i*RSP_W + RD_DATA_LSB +: DATA_W] = rd_data[i];
        end
    end

endmodule

// File: doc/cbg_lsu_responder.md
Name: cbg_lsu_responder

Overview:
- Memory-side responder for the LSU request interface used by the PE rows.
- Accepts level-held read and write requests plus an address/write-data bus from N_LSU load-store units.
- Round-robin arbitrates the requests onto one single-port data bank and returns read data and write acknowledges on the per-LSU CBG-to-LSU bus.
- Sits between the PE-row LSUs and the on-chip data bank; a host preload port fills the bank before run.

Parameters:
- N_LSU, 4, number of LSU requesters served.
- DATA_W, 32, data word width.
- ADDR_W, 10, word address width; bank depth is 2**ADDR_W words.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- r_request  in  N_LSU  per-LSU read request, level-held until answered.
- w_request  in  N_LSU  per-LSU write request, level-held until answered.
- lsu_addr_bus  in  N_LSU*(DATA_W+ADDR_W)  slice i = {wdata[DATA_W-1:0], addr[ADDR_W-1:0]} for LSU i.
- cbg_to_lsu_bus  out  N_LSU*(DATA_W+2)  slice i = {rd_valid, wr_ack, rd_data[DATA_W-1:0]}.
- host_we  in  1  host preload write strobe.
- host_addr  in  ADDR_W  host preload address.
- host_wdata  in  DATA_W  host preload data.

Behaviour:
- Interface is fixed as one clock, clk; reset rst is asynchronous and active-high.
- Reset: every cbg_to_lsu_bus bit is 0, the round-robin pointer is 0, in-flight and mask registers are cleared. Bank contents are not reset and are retained. A reset mid-operation discards any in-flight response.
- Eligibility: LSU i is eligible when (r_request[i] | w_request[i]) and LSU i is not masked. LSU i is masked in the cycle immediately after it was granted, because its response is in flight and its request is still high.
- Arbitration: combinational round-robin. The first eligible LSU at or after the pointer, wrapping N_LSU-1 to 0, wins. After a grant the pointer becomes grantee+1 mod N_LSU. With no grant the pointer is unchanged.
- Same-LSU read and write: if both r_request[i] and w_request[i] are high, the write is served first. The read is served on a later grant and returns the newly written data.
- Host priority: when host_we=1, the host write takes the bank that cycle. No LSU is granted, the pointer holds, and host_wdata is written to host_addr.
- Access timing: the grant is decided in cycle N and the bank is accessed at the end of cycle N.
  - Read: in cycle N+1, rd_valid=1 and rd_data holds the bank word for exactly one cycle.
  - Write: the bank is updated at the end of cycle N; in cycle N+1, wr_ack=1 for exactly one cycle.
  - Total latency is 1 cycle; aggregate throughput is 1 access per cycle; per-LSU throughput is at most 1 access per 2 cycles.
- Response hold: rd_data holds its last value when rd_valid=0. wr_ack and rd_valid are never both 1 in the same slice.
- LSU contract: the LSU must drop or change its request in the cycle it sees rd_valid or wr_ack. A request still high after the mask cycle is treated as a new access.
- Widths: addr spans the full bank, so there is no out-of-range case. No arithmetic beyond the modulo-N_LSU pointer increment.
- Bank state machine, two states:
  - IDLE → BUSY on any grant or host write.
  - BUSY → BUSY on a new grant.
  - BUSY → IDLE otherwise.
  - BUSY drives the response stage.

Optional Feature:
- CBG_PERF_CNT_EN defined: adds output port stall_cnt, 32 bits, reset 0.
  - Increments by 1 each cycle in which at least one LSU has an unmasked request that is not granted, including cycles lost to host writes.
  - Saturates at 32'hFFFF_FFFF.
- CBG_PERF_CNT_EN undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/include holds the response-slice field offsets (RD_VALID_BIT, WR_ACK_BIT, RD_DATA_LSB), the request-slice field offsets (ADDR_LSB, WDATA_LSB), and default DATA_W/ADDR_W/N_LSU.
- One sub-module, cbg_rr_arbiter: parameterised N_LSU round-robin arbiter taking req/mask/hold and producing a one-hot grant and the next pointer.
- Bank array and response register stay in the top module.

Test Plan:
- Host preload: host writes 0x1234_5678 to addr 5; then LSU0 reads addr 5 → rd_valid[0]=1 with rd_data=0x1234_5678 one cycle after grant; other slices stay 0.
- Contention: all four LSUs raise r_request together on distinct addresses 1..4 holding 0xA1..0xA4. Grants occur in order 0,1,2,3 on consecutive cycles; each rd_valid pulses once with the matching value; the pointer returns to 0.
- Write then read, same LSU: LSU2 raises w_request and r_request on addr 9 with wdata 0xDEAD_BEEF. wr_ack[2] fires first, then rd_valid[2] with 0xDEAD_BEEF.
- Host blocking: host_we=1 in the same cycle LSU1 requests. There is no LSU1 response in the next cycle; LSU1 is granted the cycle after and its response arrives one cycle later.
- Reset mid-flight: assert rst in the cycle a read response is due. All cbg_to_lsu_bus bits are 0 immediately (asynchronous) and remain 0 after release; the pointer restarts at 0, so LSU0 wins the next contention.
- CBG_PERF_CNT_EN: four simultaneous held requests for 4 cycles → stall_cnt=3 once all four are served.
